// File: rtl/ys_poly_small_seq3.sv
// Mode-3 pass sequencer: streams every coefficient block out of ram1 and
// writes the exe3 datapath result back into ram2 in ascending block order.
module ys_poly_small_seq3 #(
  parameter int NUM_BLK  = 64,
  parameter int AW       = 7,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ram1_ena,
  output logic [AW-1:0] ram1_addra,
  output logic          ram1_enb,
  output logic [AW-1:0] ram1_addrb,
  output logic          ram2_wea,
  output logic [AW-1:0] ram2_addra,
  output logic          ram2_web,
  output logic [AW-1:0] ram2_addrb,
  output logic          f_ctr
);

  localparam int KW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_BLK - 1);
  localparam logic [DW-1:0] D_LAST = DW'(READ_LAT - 1);

  // Handshake: none on the RAM side; a read issued in cycle t (ena=1) has its
  // data valid in cycle t+READ_LAT, which is exactly when the shift line
  // output raises the matching ram2 write enables.
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e                      state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [DW-1:0]               dcnt_q, dcnt_d;
  logic [READ_LAT-1:0]         sl_v_q, sl_v_d;
  logic [READ_LAT-1:0]         sl_f_q, sl_f_d;
  logic [READ_LAT-1:0][KW-1:0] sl_k_q, sl_k_d;
  logic [AW-1:0]               r1b_q, r1b_d;
  logic [AW-1:0]               r2a_q, r2a_d;
  logic [AW-1:0]               r2b_q, r2b_d;

  logic          issue;
  logic          wr_v;
  logic          wr_f;
  logic [KW-1:0] wr_k;

  assign issue = (state_q == S_READ);
  assign wr_v  = sl_v_q[READ_LAT-1];
  assign wr_f  = sl_f_q[READ_LAT-1];
  assign wr_k  = sl_k_q[READ_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (k_q == K_LAST) state_d = S_DRAIN;
      S_DRAIN: if (dcnt_q == D_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and the (valid, k, first) shift line; k holds after the last
  // block so the idle addresses stay at their final values.
  always_comb begin
    k_d    = k_q;
    dcnt_d = dcnt_q;
    if (state_q == S_IDLE && start) begin
      k_d = '0;
    end else if (issue && k_q != K_LAST) begin
      k_d = k_q + 1'b1;
    end
    if (issue) begin
      dcnt_d = '0;
    end else if (state_q == S_DRAIN) begin
      dcnt_d = dcnt_q + 1'b1;
    end
    sl_v_d    = sl_v_q;
    sl_f_d    = sl_f_q;
    sl_k_d    = sl_k_q;
    sl_v_d[0] = issue;
    sl_f_d[0] = (k_q == '0);
    sl_k_d[0] = k_q;
    for (int i = 1; i < READ_LAT; i++) begin
      sl_v_d[i] = sl_v_q[i-1];
      sl_f_d[i] = sl_f_q[i-1];
      sl_k_d[i] = sl_k_q[i-1];
    end
    r1b_d = issue ? AW'({k_q, 1'b1}) : r1b_q;
    r2a_d = wr_v ? AW'({wr_k, 1'b0}) : r2a_q;
    r2b_d = wr_v ? AW'({wr_k, 1'b1}) : r2b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      dcnt_q <= '0;
      sl_v_q <= '0;
      sl_f_q <= '0;
      sl_k_q <= '0;
      r1b_q  <= '0;
      r2a_q  <= '0;
      r2b_q  <= '0;
    end else begin
      k_q    <= k_d;
      dcnt_q <= dcnt_d;
      sl_v_q <= sl_v_d;
      sl_f_q <= sl_f_d;
      sl_k_q <= sl_k_d;
      r1b_q  <= r1b_d;
      r2a_q  <= r2a_d;
      r2b_q  <= r2b_d;
    end
  end

  always_comb begin
    busy       = (state_q == S_READ) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    ram1_ena   = issue;
    ram1_enb   = issue;
    ram1_addra = AW'({k_q, 1'b0});
    ram1_addrb = issue ? AW'({k_q, 1'b1}) : r1b_q;
    ram2_wea   = wr_v;
    ram2_web   = wr_v;
    ram2_addra = wr_v ? AW'({wr_k, 1'b0}) : r2a_q;
    ram2_addrb = wr_v ? AW'({wr_k, 1'b1}) : r2b_q;
    f_ctr      = ~(wr_v & wr_f);
  end

endmodule

// File: tb/tb_ys_poly_small_seq3.sv
// Bench for ys_poly_small_seq3: cycle table for a nominal pass, write
// scoreboard, exe3 golden model, async-reset abort and a READ_LAT=3 instance.
module tb_ys_poly_small_seq3;

  localparam int NB = 64, AW = 7, RL = 1;
  localparam int NB_B = 4, AW_B = 3, RL_B = 3;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst, start, start_b;
  always #5 clk = ~clk;
  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  logic a_busy, a_done, a_ena, a_enb, a_wea, a_web, a_f_ctr;
  logic [AW-1:0] a_addra, a_addrb, a_waddra, a_waddrb;
  logic b_busy, b_done, b_ena, b_enb, b_wea, b_web, b_f_ctr;
  logic [AW_B-1:0] b_addra, b_addrb, b_waddra, b_waddrb;

  ys_poly_small_seq3 #(.NUM_BLK(NB), .AW(AW), .READ_LAT(RL)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(a_busy), .done(a_done),
    .ram1_ena(a_ena), .ram1_addra(a_addra), .ram1_enb(a_enb), .ram1_addrb(a_addrb),
    .ram2_wea(a_wea), .ram2_addra(a_waddra), .ram2_web(a_web), .ram2_addrb(a_waddrb),
    .f_ctr(a_f_ctr));

  ys_poly_small_seq3 #(.NUM_BLK(NB_B), .AW(AW_B), .READ_LAT(RL_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .ram1_ena(b_ena), .ram1_addra(b_addra), .ram1_enb(b_enb), .ram1_addrb(b_addrb),
    .ram2_wea(b_wea), .ram2_addra(b_waddra), .ram2_web(b_web), .ram2_addrb(b_waddrb),
    .f_ctr(b_f_ctr));

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ram1 / ram2 models and exe3 datapath model
  logic [12:0] g [0:NB*8-1];
  logic [51:0] mem1 [0:2*NB-1];
  logic [51:0] mem2 [0:2*NB-1];
  logic [51:0] rda, rdb;
  logic [12:0] carry;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (a_ena) begin
      rda <= mem1[a_addra];
      rdb <= mem1[a_addrb];
    end
  end

  // scoreboard
  always @(negedge clk) begin : mon
    logic [12:0] c [8];
    logic [12:0] prev;
    logic [51:0] wa, wb;
    logic [W-1:0] act, e;
    if (a_done) done_cnt++;
    if (a_wea || a_web) begin
      act = {gcyc[15:0], a_waddra, a_waddrb, a_f_ctr, a_web};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("write", {32'd0, act}, {32'd0, e});
      end
      for (int j = 0; j < 4; j++) begin
        c[j]   = rda[13*j +: 13];
        c[j+4] = rdb[13*j +: 13];
      end
      prev = a_f_ctr ? carry : 13'd0;
      for (int j = 0; j < 8; j++) begin
        if (j < 4) wa[13*j +: 13] = 13'(3 * (prev - c[j]));
        else       wb[13*(j-4) +: 13] = 13'(3 * (prev - c[j]));
        prev = c[j];
      end
      carry = c[7];
      mem2[a_waddra] = wa;
      mem2[a_waddrb] = wb;
    end
  end

  logic [W-1:0] b_log[$];
  int b_done_cyc = -1;
  always @(negedge clk) begin
    if (b_wea) b_log.push_back({8'd0, gcyc[15:0], b_waddra, b_waddrb, b_f_ctr, b_web});
    if (b_done) b_done_cyc = gcyc;
  end

  // driver tasks
  task automatic load_mem();
    for (int i = 0; i < NB*8; i++) g[i] = 13'($urandom_range(0, 8191));
    for (int w = 0; w < 2*NB; w++) begin
      mem1[w] = {g[4*w+3], g[4*w+2], g[4*w+1], g[4*w]};
      mem2[w] = '0;
    end
  endtask

  task automatic push_pass(input int s);
    for (int k = 0; k < NB; k++)
      exp_q.push_back({16'(s + k + 1 + RL), 7'(2*k), 7'(2*k+1), (k != 0), 1'b1});
  endtask

  task automatic golden(input string tag);
    logic [51:0] ew;
    logic [12:0] v;
    for (int w = 0; w < 2*NB; w++) begin
      for (int j = 0; j < 4; j++) begin
        int i;
        i = 4*w + j;
        if (i == 0) v = 13'(0 - 3 * g[0]);
        else        v = 13'(3 * g[i-1] - 3 * g[i]);
        ew[13*j +: 13] = v;
      end
      check(tag, {12'd0, mem2[w]}, {12'd0, ew});
    end
  endtask

  function automatic logic [63:0] pack_a();
    return {29'd0, a_busy, a_done, a_ena, a_enb, a_addra, a_addrb,
            a_wea, a_web, a_waddra, a_waddrb, a_f_ctr};
  endfunction

  function automatic logic [63:0] exp_a(input logic bsy, input logic dn, input logic en,
      input int ra, input int rb, input logic we, input int wa, input int wb, input logic fc);
    return {29'd0, bsy, dn, en, en, 7'(ra), 7'(rb), we, we, 7'(wa), 7'(wb), fc};
  endfunction

  typedef struct {
    int c; logic st; logic busy; logic done; logic ena;
    int ra; int rb; logic wea; int wa; int wb; logic fc;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int ti, s;
    bit found;
    tbl[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 0,   0,   1'b0, 0,   0,   1'b1};
    tbl[1]  = '{1,  1'b0, 1'b1, 1'b0, 1'b1, 0,   1,   1'b0, 0,   0,   1'b1};
    tbl[2]  = '{2,  1'b0, 1'b1, 1'b0, 1'b1, 2,   3,   1'b1, 0,   1,   1'b0};
    tbl[3]  = '{3,  1'b0, 1'b1, 1'b0, 1'b1, 4,   5,   1'b1, 2,   3,   1'b1};
    tbl[4]  = '{10, 1'b1, 1'b1, 1'b0, 1'b1, 18,  19,  1'b1, 16,  17,  1'b1};
    tbl[5]  = '{64, 1'b0, 1'b1, 1'b0, 1'b1, 126, 127, 1'b1, 124, 125, 1'b1};
    tbl[6]  = '{65, 1'b0, 1'b1, 1'b0, 1'b0, 126, 127, 1'b1, 126, 127, 1'b1};
    tbl[7]  = '{66, 1'b1, 1'b0, 1'b1, 1'b0, 126, 127, 1'b0, 126, 127, 1'b1};
    tbl[8]  = '{67, 1'b0, 1'b0, 1'b0, 1'b0, 126, 127, 1'b0, 126, 127, 1'b1};
    tbl[9]  = '{68, 1'b0, 1'b0, 1'b0, 1'b0, 126, 127, 1'b0, 126, 127, 1'b1};
    tbl[10] = '{69, 1'b0, 1'b0, 1'b0, 1'b0, 126, 127, 1'b0, 126, 127, 1'b1};

    rst = 1'b1; start = 1'b0; start_b = 1'b0; carry = '0;
    load_mem();
    repeat (3) @(negedge clk);
    check("reset_a", pack_a(), exp_a(0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("reset_b", {b_busy, b_done, b_ena, b_enb, b_addra, b_addrb, b_wea, b_web,
                      b_waddra, b_waddrb, b_f_ctr}, 23'h1);
    rst = 1'b0;

    // nominal pass with ignored starts at cycles 10 and 66
    ti = 0;
    for (int c = 0; c <= 70; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (ti < 11 && tbl[ti].c == c) begin
        check($sformatf("vec_c%0d", c), pack_a(),
              exp_a(tbl[ti].busy, tbl[ti].done, tbl[ti].ena, tbl[ti].ra, tbl[ti].rb,
                    tbl[ti].wea, tbl[ti].wa, tbl[ti].wb, tbl[ti].fc));
        start = tbl[ti].st;
        ti++;
      end
      if (c == 0) push_pass(gcyc);
    end
    start = 1'b0;
    check("nom_done_cnt", 64'(done_cnt), 64'd1);
    check("nom_q_empty", 64'(exp_q.size()), 64'd0);
    golden("nom_ram2");

    // new pass from IDLE, aborted by an async reset in cycle 30
    load_mem();
    @(negedge clk);
    s = gcyc;
    start = 1'b1;
    push_pass(s);
    @(negedge clk);
    start = 1'b0;
    repeat (28) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async", pack_a(), exp_a(0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {62'd0, a_busy, a_ena}, 64'd0);
    end

    // restart yields a full correct result
    load_mem();
    done_cnt = 0;
    @(negedge clk);
    s = gcyc;
    start = 1'b1;
    push_pass(s);
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (a_done) begin
        found = 1;
        check("restart_done_cyc", 64'(gcyc), 64'(s + NB + RL + 1));
      end else begin
        @(negedge clk);
      end
    end
    if (!found) check("restart_done_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
    check("restart_done_cnt", 64'(done_cnt), 64'd1);
    check("restart_q_empty", 64'(exp_q.size()), 64'd0);
    golden("restart_ram2");

    // READ_LAT=3, NUM_BLK=4 instance
    @(negedge clk);
    s = gcyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (12) @(negedge clk);
    check("b_write_count", 64'(b_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < b_log.size(); k++)
      check($sformatf("b_write_k%0d", k), {32'd0, b_log[k]},
            {32'd0, 8'd0, 16'(s + 4 + k), 3'(2*k), 3'(2*k+1), (k != 0), 1'b1});
    check("b_done_cyc", 64'(b_done_cyc), 64'(s + 8));
    check("b_idle", {62'd0, b_busy, b_ena}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
